// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared geometry defaults, counter widths and capture FSM encoding
//
// Purpose : constants and types shared by the camera capture path.
// Ports   : none (package).

package video_pkg;

  // 1024 x 768 x 1 word fills the SDRAM write window (max address 786432).
  localparam int H_PIXELS_DEF    = 1024;
  localparam int V_LINES_DEF     = 768;
  localparam int SKIP_FRAMES_DEF = 10;

  localparam int PIX_CNT_W  = 11;
  localparam int LINE_CNT_W = 11;
  localparam int SKIP_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_SKIP    = 2'd2,
    ST_CAPTURE = 2'd3
  } cap_state_t;

endpackage

// File: rtl/dvp_byte_packer.sv
// rtl/dvp_byte_packer.sv - DVP input registering, edge detection and byte-to-RGB565 pairing
//
// Purpose : registers the camera inputs once, detects vsync/href edges and packs
//           byte pairs (high byte first) into 16-bit words with a 2-cycle latency.
// Ports   : clk, rst_n         clock, async active-low reset
//           i_enable           pairing allowed (capture state, frame in progress)
//           i_cam_vsync/href   camera sync inputs
//           i_cam_data[7:0]    camera byte
//           o_we, o_data[15:0] pixel write strobe and word
//           o_vs_rise/o_vs_fall registered-vsync edges
//           o_line_end         href fall closing an active line (enabled only)
//           o_line_ok          line had exactly H_PIXELS pixels and no odd byte

module dvp_byte_packer
  import video_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_cam_vsync,
  input  logic        i_cam_href,
  input  logic [7:0]  i_cam_data,
  output logic        o_we,
  output logic [15:0] o_data,
  output logic        o_vs_rise,
  output logic        o_vs_fall,
  output logic        o_line_end,
  output logic        o_line_ok
);

  logic                 r_vs_d, r_vs_d2, r_href_d, r_href_d2;
  logic [7:0]           r_data_d, r_hi;
  logic                 r_phase;
  logic [PIX_CNT_W-1:0] r_pix_cnt;
  logic                 r_we;
  logic [15:0]          r_data;

  logic w_href_fall, w_byte_en;

  assign o_vs_rise   = r_vs_d & ~r_vs_d2;
  assign o_vs_fall   = ~r_vs_d & r_vs_d2;
  assign w_href_fall = r_href_d2 & ~r_href_d;
  // A line only counts if vsync was low while it ran; this also lets a vsync
  // rise and an href fall land in the same cycle with the line closed first.
  assign o_line_end  = i_enable & w_href_fall & ~r_vs_d2;
  assign o_line_ok   = (r_pix_cnt == PIX_CNT_W'(H_PIXELS)) & ~r_phase;
  assign w_byte_en   = i_enable & ~r_vs_d & r_href_d;

  assign o_we   = r_we;
  assign o_data = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d    <= 1'b0;
      r_vs_d2   <= 1'b0;
      r_href_d  <= 1'b0;
      r_href_d2 <= 1'b0;
      r_data_d  <= 8'd0;
      r_hi      <= 8'd0;
      r_phase   <= 1'b0;
      r_pix_cnt <= '0;
      r_we      <= 1'b0;
      r_data    <= 16'd0;
    end else begin
      r_vs_d    <= i_cam_vsync;
      r_vs_d2   <= r_vs_d;
      r_href_d  <= i_cam_href;
      r_href_d2 <= r_href_d;
      r_data_d  <= i_cam_data;
      r_we      <= 1'b0;
      if (!i_enable || o_line_end) begin
        // Odd trailing byte sitting in r_hi is simply abandoned here.
        r_phase   <= 1'b0;
        r_pix_cnt <= '0;
      end else if (w_byte_en) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_hi <= r_data_d;
        end else begin
          r_we   <= 1'b1;
          r_data <= {r_hi, r_data_d};
          // Saturate so a runaway line can never wrap back to a "good" count.
          if (r_pix_cnt != '1) r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/frame_capture_writer.sv
// rtl/frame_capture_writer.sv - camera frame capture into the SDRAM FIFO write port
//
// Purpose : gates capture on SDRAM init and sensor settling, writes RGB565 words,
//           pulses wr_load at each frame start and reports frame geometry status.
// Ports   : clk, rst_n                  clock, async active-low reset
//           sdram_init_done             SDRAM controller ready (level)
//           cam_vsync/cam_href/cam_data DVP camera inputs
//           sys_we, sys_data_in[15:0]   FIFO write strobe and pixel
//           wr_load                     write-address reset pulse at frame start
//           frame_valid                 high in CAPTURE state
//           frame_done                  pulse at end of a correctly sized frame
//           frame_err                   set at end of a bad frame, cleared at frame start

module frame_capture_writer
  import video_pkg::*;
#(
  parameter int H_PIXELS    = H_PIXELS_DEF,
  parameter int V_LINES     = V_LINES_DEF,
  parameter int SKIP_FRAMES = SKIP_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        sys_we,
  output logic [15:0] sys_data_in,
  output logic        wr_load,
  output logic        frame_valid,
  output logic        frame_done,
  output logic        frame_err
);

  cap_state_t            r_state, w_next_state;
  logic [SKIP_CNT_W-1:0] r_skip_cnt, w_skip_inc;
  logic [LINE_CNT_W-1:0] r_line_cnt, w_line_cnt_nx;
  logic                  r_bad_line, w_bad_nx;
  logic                  r_frame_active;
  logic                  r_wr_load, r_frame_done, r_frame_err;

  logic w_vs_rise, w_vs_fall, w_line_end, w_line_ok;
  logic w_capture, w_live, w_enable;

  assign w_capture = (r_state == ST_CAPTURE);
  // Frame bookkeeping stops the cycle init drops, so an abandoned frame never completes.
  assign w_live    = w_capture & sdram_init_done;
  assign w_enable  = w_capture & r_frame_active;
  assign w_skip_inc = r_skip_cnt + SKIP_CNT_W'(1);

  dvp_byte_packer #(.H_PIXELS(H_PIXELS)) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_enable    (w_enable),
    .i_cam_vsync (cam_vsync),
    .i_cam_href  (cam_href),
    .i_cam_data  (cam_data),
    .o_we        (sys_we),
    .o_data      (sys_data_in),
    .o_vs_rise   (w_vs_rise),
    .o_vs_fall   (w_vs_fall),
    .o_line_end  (w_line_end),
    .o_line_ok   (w_line_ok)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (sdram_init_done) w_next_state = ST_SYNC;
      ST_SYNC: begin
        if (!sdram_init_done) w_next_state = ST_IDLE;
        else if (w_vs_rise)   w_next_state = (SKIP_FRAMES == 0) ? ST_CAPTURE : ST_SKIP;
      end
      ST_SKIP: begin
        if (!sdram_init_done) w_next_state = ST_IDLE;
        else if (w_vs_rise && (w_skip_inc >= SKIP_CNT_W'(SKIP_FRAMES))) w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: if (!sdram_init_done) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Line close is folded in before frame evaluation so same-cycle edges work.
  always_comb begin
    w_line_cnt_nx = r_line_cnt;
    w_bad_nx      = r_bad_line;
    if (w_line_end && w_live) begin
      if (r_line_cnt != '1) w_line_cnt_nx = r_line_cnt + LINE_CNT_W'(1);
      if (!w_line_ok)       w_bad_nx      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_skip_cnt     <= '0;
      r_line_cnt     <= '0;
      r_bad_line     <= 1'b0;
      r_frame_active <= 1'b0;
      r_wr_load      <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_wr_load    <= 1'b0;
      r_frame_done <= 1'b0;

      if (r_state == ST_SYNC)                r_skip_cnt <= '0;
      else if (r_state == ST_SKIP && w_vs_rise) r_skip_cnt <= w_skip_inc;

      if (!w_live) begin
        r_frame_active <= 1'b0;
      end else if (w_vs_fall) begin
        r_wr_load      <= 1'b1;
        r_line_cnt     <= '0;
        r_bad_line     <= 1'b0;
        r_frame_err    <= 1'b0;
        r_frame_active <= 1'b1;
      end else if (r_frame_active) begin
        r_line_cnt <= w_line_cnt_nx;
        r_bad_line <= w_bad_nx;
        if (w_vs_rise) begin
          r_frame_active <= 1'b0;
          if ((w_line_cnt_nx == LINE_CNT_W'(V_LINES)) && !w_bad_nx) r_frame_done <= 1'b1;
          else                                                     r_frame_err  <= 1'b1;
        end
      end
    end
  end

  assign wr_load     = r_wr_load;
  assign frame_valid = w_capture;
  assign frame_done  = r_frame_done;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_frame_capture_writer.sv
// tb/tb_frame_capture_writer.sv - directed self-checking bench for frame_capture_writer

module tb_frame_capture_writer;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int SKIP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdram_init_done = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic        sys_we;
  logic [15:0] sys_data_in;
  logic        wr_load, frame_valid, frame_done, frame_err;

  always #5 clk = ~clk;

  frame_capture_writer #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(SKIP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .cam_vsync       (cam_vsync),
    .cam_href        (cam_href),
    .cam_data        (cam_data),
    .sys_we          (sys_we),
    .sys_data_in     (sys_data_in),
    .wr_load         (wr_load),
    .frame_valid     (frame_valid),
    .frame_done      (frame_done),
    .frame_err       (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int we_total = 0, load_total = 0, done_total = 0;
  logic [15:0] wr_data [0:255];
  int          wr_cyc  [0:255];
  logic [15:0] pix_tab [0:7];
  int          first_lo_cyc = 0;
  logic        err_at_start = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sys_we) begin
      wr_data[we_total & 255] <= sys_data_in;
      wr_cyc[we_total & 255]  <= cyc;
      we_total <= we_total + 1;
    end
    if (wr_load)    load_total <= load_total + 1;
    if (frame_done) done_total <= done_total + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bytes of pixel (pix0 + b/2): high byte on even b, low byte on odd b.
  task automatic send_line(input int nbytes, input int pix0);
    logic [15:0] w;
    for (int b = 0; b < nbytes; b++) begin
      w = pix_tab[(pix0 + b / 2) % 8];
      cam_href = 1'b1;
      cam_data = (b % 2 == 0) ? w[15:8] : w[7:0];
      if (b == 1 && pix0 == 0) first_lo_cyc = cyc;
      step();
    end
    cam_href = 1'b0;
    cam_data = 8'd0;
  endtask

  task automatic run_frame(input int n0, input int n1, input bit simult);
    cam_vsync = 1'b0;
    step(3);
    err_at_start = frame_err;
    send_line(n0, 0);
    step(3);
    send_line(n1, H);
    if (!simult) step(3);
    cam_vsync = 1'b1;
    step(6);
  endtask

  task automatic check_data(input string tag, input int base, input int p0, input int p1);
    for (int i = 0; i < p0; i++)
      check_eq(tag, wr_data[(base + i) & 255], pix_tab[i]);
    for (int j = 0; j < p1; j++)
      check_eq(tag, wr_data[(base + p0 + j) & 255], pix_tab[H + j]);
  endtask

  int base_we, base_ld, base_dn;

  task automatic mark();
    base_we = we_total;
    base_ld = load_total;
    base_dn = done_total;
  endtask

  initial begin
    pix_tab[0] = 16'hF800; pix_tab[1] = 16'h07E0; pix_tab[2] = 16'h001F; pix_tab[3] = 16'hFFFF;
    pix_tab[4] = 16'h1234; pix_tab[5] = 16'hABCD; pix_tab[6] = 16'h0000; pix_tab[7] = 16'h8001;

    step(3);
    check_eq("rst_sys_we", sys_we, 0);
    check_eq("rst_data", sys_data_in, 0);
    check_eq("rst_wr_load", wr_load, 0);
    check_eq("rst_frame_valid", frame_valid, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    step(2);

    // Init held low for three complete frames.
    mark();
    repeat (3) run_frame(8, 8, 0);
    check_eq("gate_writes", we_total - base_we, 0);
    check_eq("gate_loads", load_total - base_ld, 0);
    check_eq("gate_valid", frame_valid, 0);

    // Init up: first frame syncs, next two are skipped.
    sdram_init_done = 1'b1;
    step(2);
    run_frame(8, 8, 0);
    run_frame(8, 8, 0);
    check_eq("skip_valid", frame_valid, 0);
    run_frame(8, 8, 0);
    check_eq("skip_done_valid", frame_valid, 1);
    check_eq("skip_writes", we_total - base_we, 0);
    check_eq("skip_loads", load_total - base_ld, 0);
    check_eq("skip_dones", done_total - base_dn, 0);

    // Nominal frame.
    mark();
    run_frame(8, 8, 0);
    check_eq("nom_writes", we_total - base_we, 8);
    check_eq("nom_loads", load_total - base_ld, 1);
    check_eq("nom_done", done_total - base_dn, 1);
    check_eq("nom_err", frame_err, 0);
    check_eq("nom_latency", wr_cyc[base_we & 255] - first_lo_cyc, 2);
    check_data("nom_data", base_we, 4, 4);

    // Short second line.
    mark();
    run_frame(8, 6, 0);
    check_eq("short_writes", we_total - base_we, 7);
    check_eq("short_done", done_total - base_dn, 0);
    check_eq("short_err", frame_err, 1);
    check_data("short_data", base_we, 4, 3);

    // Odd trailing byte on line 0.
    mark();
    run_frame(9, 8, 0);
    check_eq("odd_err_cleared", err_at_start, 0);
    check_eq("odd_writes", we_total - base_we, 8);
    check_eq("odd_done", done_total - base_dn, 0);
    check_eq("odd_err", frame_err, 1);
    check_data("odd_data", base_we, 4, 4);

    // Extra pixel on line 0: still written, frame flagged.
    mark();
    run_frame(10, 8, 0);
    check_eq("extra_writes", we_total - base_we, 9);
    check_eq("extra_done", done_total - base_dn, 0);
    check_eq("extra_err", frame_err, 1);

    // vsync rise and href fall in the same cycle on a good frame.
    mark();
    run_frame(8, 8, 1);
    check_eq("simul_writes", we_total - base_we, 8);
    check_eq("simul_done", done_total - base_dn, 1);
    check_eq("simul_err", frame_err, 0);

    // Init lost mid-line after three pixels.
    mark();
    cam_vsync = 1'b0;
    step(3);
    for (int b = 0; b < 10; b++) begin
      cam_href = 1'b1;
      cam_data = 8'(8'h40 + b);
      if (b == 6) sdram_init_done = 1'b0;
      step();
    end
    cam_href = 1'b0;
    step(3);
    cam_vsync = 1'b1;
    step(6);
    check_eq("loss_writes", we_total - base_we, 3);
    check_eq("loss_word2", wr_data[(base_we + 2) & 255], 16'h4445);
    check_eq("loss_valid", frame_valid, 0);
    check_eq("loss_done", done_total - base_dn, 0);
    check_eq("loss_err", frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_capture_writer.md
Name: frame_capture_writer

Overview:
- Capture-side counterpart of the SDRAM-to-LCD display path: turns a DVP-style 8-bit camera byte stream (vsync/href/data, sampled in the single system clock domain) into 16-bit RGB565 words on the FIFO write interface (sys_we/sys_data_in) of the SDRAM 2-FIFO controller.
- Generates the write-address reset (wr_load) at each frame start.
- Gates capture until SDRAM init completes and the sensor has settled.
- Reports frame completion and geometry errors.

Parameters:
- H_PIXELS, 1024, 16-bit pixels per line (2*H_PIXELS bytes per href).
- V_LINES, 768, lines per frame.
- SKIP_FRAMES, 10, complete frames discarded after init before capture starts (0 = none).

Ports:
- clk  in  1  system clock (same clock as the SDRAM FIFO write side).
- rst_n  in  1  asynchronous active-low reset.
- sdram_init_done  in  1  SDRAM controller init complete (level).
- cam_vsync  in  1  high = vertical blanking; falling edge = frame start, rising edge = frame end.
- cam_href  in  1  high = active line bytes on cam_data.
- cam_data  in  8  pixel byte; high byte first (R5G3), then low byte (G3B5).
- sys_we  out  1  FIFO write strobe, one cycle per pixel.
- sys_data_in  out  16  RGB565 pixel; valid when sys_we=1.
- wr_load  out  1  one-cycle pulse resetting the SDRAM write address to 0.
- frame_valid  out  1  high while in CAPTURE state.
- frame_done  out  1  one-cycle pulse at end of a frame with correct geometry.
- frame_err  out  1  set at end of a bad frame; cleared at next frame start.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters, byte phase and edge registers 0.
- Inputs are registered once (vs_d, href_d, data_d). Edges come from vs_d versus its previous value. Fixed pipeline: a byte on cam_data at cycle N yields sys_we at N+2 if it completes a pixel.
- FSM:
  - IDLE: wait sdram_init_done=1, then go to SYNC.
  - SYNC: wait vsync rising edge (frame end), then go to SKIP, or to CAPTURE if SKIP_FRAMES=0. The first partial frame is ignored.
  - SKIP: count vsync rising edges. When the count reaches SKIP_FRAMES, go to CAPTURE. No sys_we or wr_load in this state.
  - CAPTURE: terminal. Leaves only on reset, or to IDLE if sdram_init_done falls. A frame in progress is then abandoned: no frame_done, frame_err unchanged.
- Frame start (vsync falling edge, CAPTURE): wr_load pulses 1 cycle; pixel/line counters and byte phase clear; frame_err clears.
- Byte pairing, in CAPTURE with vs_d=0 and href_d=1:
  - phase 0: latch the byte as the high byte.
  - phase 1: form {hi, byte}, assert sys_we, increment pix_cnt (11 bits). Phase toggles each byte.
- Line end (href falling edge, active frame):
  - line_ok = (pix_cnt==H_PIXELS and phase==0).
  - The odd trailing byte is discarded, never written.
  - line_cnt increments (saturating at 2047); the bad-line flag is set if !line_ok.
  - pix_cnt and phase clear.
- Extra pixels beyond H_PIXELS in a line are still written, but flag the line bad. sys_we is never suppressed mid-line, so the downstream FIFO count stays deterministic.
- href high while vs_d=1 is ignored: no writes, no counting.
- Frame end (vsync rising edge, CAPTURE, after a valid frame start):
  - If line_cnt==V_LINES and no bad line: frame_done pulses 1 cycle.
  - Otherwise frame_err is set.
- Simultaneous edges: vsync rising and href falling in the same cycle ⇒ close the line first, then evaluate the frame. Same-cycle frame start and href activity ⇒ counters clear; the byte is ignored.
- sdram_init_done deasserting in SKIP or SYNC returns the FSM to IDLE.

Decomposition:
- Shared package (video_pkg): H_PIXELS/V_LINES defaults (1024/768, consistent with the SDRAM max address 786432) and the FSM state encoding (IDLE, SYNC, SKIP, CAPTURE, 2 bits).
- One natural sub-module: dvp_byte_packer. It does input registering, edge detection, byte pairing and pix_cnt, and outputs sys_we/sys_data_in and a line-end/line_ok strobe.
- The top holds the FSM, skip counter, line counter and frame status.

Test Plan:
- Init gating: sdram_init_done held 0 for 3 frames with H=4, V=2 → no sys_we, no wr_load. Then init=1 with SKIP_FRAMES=2 → first wr_load on the frame start after the 3rd vsync rise.
- Nominal frame (H=4, V=2, SKIP=0): bytes 0xF8,0x00,0x07,0xE0,... → sys_data_in 0xF800, 0x07E0 with sys_we 2 cycles after the low byte. Expect 8 writes, 1 wr_load, 1 frame_done, frame_err=0.
- Short line: line 1 has 3 pixels → 7 writes total, frame_done=0, frame_err=1 at vsync rise. frame_err clears at the next vsync fall.
- Odd byte: line ends with 9 bytes (H=4) → 4 writes; trailing byte dropped; frame_err=1.
- Mid-frame init loss: sdram_init_done drops after 3 pixels → FSM IDLE, frame_valid=0, no further sys_we, no frame_done.
- Simultaneous vsync rise and href fall on the last line of a correct frame → frame_done=1, frame_err=0.
